// File: rtl/frame_burst_writer.sv
// Buffers the receive-side pixel stream and writes it to DDR3 as fixed-length bursts,
// ping-ponging whole frames between two banks. Build option FRAME_LEN_CHECK_EN rejects bad frames.
module frame_burst_writer #(
    parameter int                ADDR_W      = 27,
    parameter int                BURST_LEN   = 64,
    parameter int                FIFO_DEPTH  = 256,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = 27'h0000000,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = 27'h0040000,
    parameter int                FRAME_WORDS = 172800
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_vs,
    input  logic                        in_wr_en,
    input  logic [15:0]                 in_wr_data,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_W-1:0]           cmd_addr,
    output logic [$clog2(BURST_LEN):0]  cmd_len,
    output logic                        wdata_valid,
    input  logic                        wdata_ready,
    output logic [15:0]                 wdata,
    output logic                        wdata_last,
    output logic                        rd_bank,
    output logic                        frame_done,
`ifdef FRAME_LEN_CHECK_EN
    output logic                        frame_err,
`endif
    output logic                        ovf
);
    localparam int LEN_W = $clog2(BURST_LEN) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // state  | meaning
    // S_IDLE | waiting for a full burst, a flush remainder, or end of flush
    // S_CMD  | presenting the burst command
    // S_DATA | streaming cmd_len words out of the FIFO
    // S_DONE | one cycle: publish the finished frame and swap banks
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    logic [15:0]       mem [FIFO_DEPTH];
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              vs_q, frame_act_q, frame_act_d, flush_q, flush_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d, cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d, rem_q, rem_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic              cmd_valid_q, cmd_valid_d, wdata_valid_q, wdata_valid_d;
    logic              wdata_last_q, wdata_last_d, frame_done_q, frame_done_d;
`ifdef FRAME_LEN_CHECK_EN
    logic [31:0]       frm_cnt_q, frm_cnt_d;
    logic              frame_err_q, frame_err_d;
`endif
    logic              rise, fall, full, push, pop;

    assign rise = in_vs & ~vs_q;
    assign fall = ~in_vs & vs_q;
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push = frame_act_q & in_wr_en & ~full;
    assign pop  = wdata_valid_q & wdata_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_wr_data;
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        frame_act_d   = frame_act_q;
        flush_d       = flush_q;
        ovf_d         = ovf_q;
        word_ptr_d    = word_ptr_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        rem_d         = rem_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        cmd_valid_d   = cmd_valid_q;
        wdata_valid_d = wdata_valid_q;
        wdata_last_d  = wdata_last_q;
        frame_done_d  = 1'b0;
`ifdef FRAME_LEN_CHECK_EN
        frm_cnt_d     = frm_cnt_q + 32'(push);
        frame_err_d   = 1'b0;
`endif
        if (frame_act_q && in_wr_en && full) ovf_d = 1'b1;
        // Only an accepted frame can end; the fall of an ignored frame must not re-arm flush.
        if (fall && frame_act_q) begin
            frame_act_d = 1'b0;
            flush_d     = 1'b1;
        end
        if (rise && !frame_act_q && !flush_q && state_q == S_IDLE) begin
            frame_act_d = 1'b1;
            word_ptr_d  = '0;
            ovf_d       = 1'b0;
`ifdef FRAME_LEN_CHECK_EN
            frm_cnt_d   = '0;
`endif
        end
        case (state_q)
            S_IDLE: begin
                if (count_q >= CNT_W'(BURST_LEN) || (flush_q && count_q != '0)) begin
                    state_d     = S_CMD;
                    cmd_valid_d = 1'b1;
                    cmd_len_d   = (count_q >= CNT_W'(BURST_LEN)) ? LEN_W'(BURST_LEN)
                                                                 : LEN_W'(count_q);
                    cmd_addr_d  = (wr_bank_q ? FRAME_BASE1 : FRAME_BASE0) + word_ptr_q;
                end else if (flush_q) begin
                    state_d = S_DONE;
                    flush_d = 1'b0;
`ifdef FRAME_LEN_CHECK_EN
                    if (frm_cnt_q != 32'(FRAME_WORDS) || ovf_q) begin
                        frame_err_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        rd_bank_d    = wr_bank_q;
                        wr_bank_d    = ~wr_bank_q;
                    end
`else
                    frame_done_d = 1'b1;
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
`endif
                end
            end
            S_CMD: begin
                if (cmd_ready) begin
                    state_d       = S_DATA;
                    cmd_valid_d   = 1'b0;
                    wdata_valid_d = 1'b1;
                    rem_d         = cmd_len_q;
                    wdata_last_d  = (cmd_len_q == LEN_W'(1));
                end
            end
            S_DATA: begin
                // cmd_len never exceeds the count at latch time, so the FIFO cannot run dry here.
                if (wdata_ready) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d       = S_IDLE;
                        wdata_valid_d = 1'b0;
                        wdata_last_d  = 1'b0;
                        word_ptr_d    = word_ptr_q + ADDR_W'(cmd_len_q);
                    end else begin
                        rem_d        = rem_q - LEN_W'(1);
                        wdata_last_d = (rem_q == LEN_W'(2));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            vs_q          <= 1'b0;
            frame_act_q   <= 1'b0;
            flush_q       <= 1'b0;
            ovf_q         <= 1'b0;
            word_ptr_q    <= '0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            rem_q         <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            cmd_valid_q   <= 1'b0;
            wdata_valid_q <= 1'b0;
            wdata_last_q  <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef FRAME_LEN_CHECK_EN
            frm_cnt_q     <= '0;
            frame_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            vs_q          <= in_vs;
            frame_act_q   <= frame_act_d;
            flush_q       <= flush_d;
            ovf_q         <= ovf_d;
            word_ptr_q    <= word_ptr_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            rem_q         <= rem_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            cmd_valid_q   <= cmd_valid_d;
            wdata_valid_q <= wdata_valid_d;
            wdata_last_q  <= wdata_last_d;
            frame_done_q  <= frame_done_d;
`ifdef FRAME_LEN_CHECK_EN
            frm_cnt_q     <= frm_cnt_d;
            frame_err_q   <= frame_err_d;
`endif
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign wdata_valid = wdata_valid_q;
    assign wdata       = wdata_valid_q ? mem[rd_ptr_q] : 16'h0000;
    assign wdata_last  = wdata_last_q;
    assign rd_bank     = rd_bank_q;
    assign frame_done  = frame_done_q;
    assign ovf         = ovf_q;
`ifdef FRAME_LEN_CHECK_EN
    assign frame_err   = frame_err_q;
`endif
endmodule

// File: tb/tb_frame_burst_writer.sv
// Bench for frame_burst_writer: a table of whole frames checked by a burst/data monitor,
// plus hand-written sequences for command stall, first-command latency and reset mid-burst.
module tb_frame_burst_writer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_vs = 1'b0, in_wr_en = 1'b0;
    logic [15:0] in_wr_data = 16'h0;
    logic        cmd_valid, cmd_ready = 1'b1;
    logic [26:0] cmd_addr;
    logic [6:0]  cmd_len;
    logic        wdata_valid, wdata_ready = 1'b1;
    logic [15:0] wdata;
    logic        wdata_last, rd_bank, frame_done, ovf;
`ifdef FRAME_LEN_CHECK_EN
    logic        frame_err;
`endif

    frame_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_wr_en(in_wr_en), .in_wr_data(in_wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .wdata_last(wdata_last), .rd_bank(rd_bank), .frame_done(frame_done),
`ifdef FRAME_LEN_CHECK_EN
        .frame_err(frame_err),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Burst model: lengths are BURST_LEN until the frame's remainder, addresses advance by length.
    logic [26:0] mdl_base, mdl_ptr;
    int          mdl_rem = 0, exp_len = 0, beat = 0, bursts = 0, done_cnt = 0;
    bit          mon_en = 1'b0;
    logic [15:0] sb[$];

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (cmd_valid && cmd_ready) begin
                exp_len = (mdl_rem > 64) ? 64 : mdl_rem;
                chk("cmd_addr", 64'(cmd_addr), 64'(mdl_base + mdl_ptr));
                chk("cmd_len", 64'(cmd_len), 64'(exp_len));
                chk("cmd_data_overlap", 64'(wdata_valid), 64'(0));
                mdl_ptr = mdl_ptr + 27'(exp_len);
                mdl_rem = mdl_rem - exp_len;
                beat = 0;
                bursts++;
            end
            if (wdata_valid && wdata_ready) begin
                if (sb.size() == 0) chk("wdata_unexpected", 64'(wdata), 64'hFFFF_FFFF);
                else chk("wdata", 64'(wdata), 64'(sb.pop_front()));
                chk("wdata_last", 64'(wdata_last), 64'(beat == exp_len - 1));
                beat++;
            end
            if (frame_done) done_cnt++;
        end
    end

    typedef struct {
        int          n_words;
        int          gap;
        bit          stall;
        int          acc;
        logic [26:0] base;
        int          bursts;
        bit          rd_bank;
        bit          ovf;
    } vec_t;
    vec_t vt[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_model(input logic [26:0] base, input int acc);
        mdl_base = base; mdl_ptr = '0; mdl_rem = acc; bursts = 0; done_cnt = 0;
    endtask

    task automatic feed(input int f, input int n, input int gap, input int acc);
        for (int i = 0; i < n; i++) begin
            in_wr_en   = 1'b1;
            in_wr_data = 16'(f * 4096 + i);
            if (i < acc) sb.push_back(in_wr_data);
            step();
            in_wr_en = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_seen", 64'(done_cnt != 0), 64'(1));
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'(0));
        chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'(0));
        chk({tag, "_cmd_len"}, 64'(cmd_len), 64'(0));
        chk({tag, "_wdata_valid"}, 64'(wdata_valid), 64'(0));
        chk({tag, "_wdata"}, 64'(wdata), 64'(0));
        chk({tag, "_wdata_last"}, 64'(wdata_last), 64'(0));
        chk({tag, "_rd_bank"}, 64'(rd_bank), 64'(0));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        chk({tag, "_ovf"}, 64'(ovf), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable, saw_wdata;
        int   t;
        // n_words gap stall acc base bursts rd_bank ovf
        vt[0] = '{200, 1, 1'b0, 200, 27'h0000000, 4, 1'b0, 1'b0};
        vt[1] = '{100, 0, 1'b0, 100, 27'h0040000, 2, 1'b1, 1'b0};
        vt[2] = '{300, 0, 1'b1, 256, 27'h0000000, 4, 1'b0, 1'b1};
        vt[3] = '{64,  2, 1'b0, 64,  27'h0040000, 1, 1'b1, 1'b0};
        vt[4] = '{1,   0, 1'b0, 1,   27'h0000000, 1, 1'b0, 1'b0};
        vt[5] = '{0,   0, 1'b0, 0,   27'h0040000, 0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        for (int f = 0; f < 6; f++) begin
            start_model(vt[f].base, vt[f].acc);
            wdata_ready = !vt[f].stall;
            in_vs = 1'b1;
            step();
            step();
            chk("ovf_cleared_at_start", 64'(ovf), 64'(0));
            feed(f, vt[f].n_words, vt[f].gap, vt[f].acc);
            step();
            step();
            in_vs = 1'b0;
            if (vt[f].stall) begin
                step();
                chk("ovf_after_full", 64'(ovf), 64'(1));
                wdata_ready = 1'b1;
            end
            wait_done();
            chk("bursts", 64'(bursts), 64'(vt[f].bursts));
            chk("done_pulses", 64'(done_cnt), 64'(1));
            chk("rd_bank", 64'(rd_bank), 64'(vt[f].rd_bank));
            chk("ovf_end", 64'(ovf), 64'(vt[f].ovf));
            chk("fifo_drained", 64'(sb.size()), 64'(0));
            step();
        end

        // Command held off by the controller; also first-command latency after the 64th word.
        start_model(27'h0000000, 64);
        cmd_ready = 1'b0;
        in_vs = 1'b1;
        step();
        step();
        feed(6, 64, 0, 64);
        @(negedge clk);
        chk("latency_not_early", 64'(cmd_valid), 64'(0));
        @(negedge clk);
        chk("latency_cmd_valid", 64'(cmd_valid), 64'(1));
        stable = 1'b1;
        saw_wdata = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(cmd_valid && cmd_addr == 27'h0 && cmd_len == 7'd64)) stable = 1'b0;
            if (wdata_valid) saw_wdata = 1'b1;
        end
        chk("cmd_held_stable", 64'(stable), 64'(1));
        chk("no_wdata_before_accept", 64'(saw_wdata), 64'(0));
        step();
        cmd_ready = 1'b1;
        in_vs = 1'b0;
        wait_done();
        chk("stall_bursts", 64'(bursts), 64'(1));
        chk("stall_rd_bank", 64'(rd_bank), 64'(0));
        step();

        // Reset while a burst is streaming.
        start_model(27'h0040000, 70);
        in_vs = 1'b1;
        step();
        step();
        feed(7, 70, 0, 70);
        t = 0;
        while (!wdata_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midburst_wdata_valid", 64'(wdata_valid), 64'(1));
        mon_en = 1'b0;
        rst_n = 1'b0;
        in_vs = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_reset_outputs("midburst_reset");
        step();
        rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("post_reset_idle", 64'(cmd_valid | wdata_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
